// File: rtl/ysyx_24110006_regfile_sb.sv
// General-purpose register file with a post-reset clearing sweep, optional
// write-to-read bypass and a per-register pending scoreboard for RAW hazards.
module ysyx_24110006_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  output logic                  o_busy1,
  output logic                  o_busy2,
  output logic                  o_ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   pending;
  logic                  ready;
  logic                  wr_commit;
  logic                  issue_ok;
  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;
  logic                  pend1;
  logic                  pend2;
  logic                  bypass1;
  logic                  bypass2;

  // Entry 0 and anything at or beyond NUM_REGS is never stored or tracked.
  function automatic logic legal(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  assign ready     = (state == READY) && i_reset_n;
  assign wr_commit = ready && i_valid && i_wen && legal(i_waddr);
  assign issue_ok  = ready && i_issue_valid && legal(i_issue_rd);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= CLEAR;
      ptr   <= ADDR_WIDTH'(1);
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (state == CLEAR) begin
      ptr_next = ptr + ADDR_WIDTH'(1);
      if (ptr == ADDR_WIDTH'(NUM_REGS - 1)) begin
        state_next = READY;
      end
    end
  end

  // The sweep owns the storage while clearing; writeback only lands once ready.
  always_ff @(posedge i_clock) begin
    for (int r = 1; r < NUM_REGS; r++) begin
      if (state == CLEAR && ptr == ADDR_WIDTH'(r)) begin
        regs[r] <= '0;
      end else if (wr_commit && i_waddr == ADDR_WIDTH'(r)) begin
        regs[r] <= i_wdata;
      end
    end
  end

  // A new issue to the same register outranks the writeback that clears it.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      pending <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_ok && i_issue_rd == ADDR_WIDTH'(r)) begin
          pending[r] <= 1'b1;
        end else if (wr_commit && i_waddr == ADDR_WIDTH'(r)) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    pend1   = 1'b0;
    pend2   = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (i_raddr1 == ADDR_WIDTH'(r)) begin
        stored1 = regs[r];
        pend1   = pending[r];
      end
      if (i_raddr2 == ADDR_WIDTH'(r)) begin
        stored2 = regs[r];
        pend2   = pending[r];
      end
    end
  end

  assign bypass1 = BYPASS_EN && wr_commit && (i_waddr == i_raddr1);
  assign bypass2 = BYPASS_EN && wr_commit && (i_waddr == i_raddr2);

  assign o_rdata1 = !ready ? '0 : (bypass1 ? i_wdata : stored1);
  assign o_rdata2 = !ready ? '0 : (bypass2 ? i_wdata : stored2);
  assign o_busy1  = ready && pend1 && !bypass1;
  assign o_busy2  = ready && pend2 && !bypass2;
  assign o_ready  = ready;

endmodule

// File: tb/tb_ysyx_24110006_regfile_sb.sv
// Scoreboard bench: three register-file variants (16/bypass, 16/no bypass,
// 32/bypass) share one stimulus stream; a negedge monitor drains expectations.
module tb_ysyx_24110006_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam int S_RD1   = 0;
  localparam int S_RD2   = 1;
  localparam int S_BUSY1 = 2;
  localparam int S_BUSY2 = 3;
  localparam int S_READY = 4;

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_wen = 1'b0;
  logic [AW-1:0] i_waddr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [AW-1:0] i_raddr1 = '0;
  logic [AW-1:0] i_raddr2 = '0;
  logic          i_issue_valid = 1'b0;
  logic [AW-1:0] i_issue_rd = '0;

  logic [2:0][DW-1:0] rdata1;
  logic [2:0][DW-1:0] rdata2;
  logic [2:0]         busy1;
  logic [2:0]         busy2;
  logic [2:0]         ready;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  ysyx_24110006_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(16), .BYPASS_EN(1'b1)) u_d0 (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_wen(i_wen),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .o_rdata1(rdata1[0]), .o_rdata2(rdata2[0]), .i_issue_valid(i_issue_valid),
    .i_issue_rd(i_issue_rd), .o_busy1(busy1[0]), .o_busy2(busy2[0]), .o_ready(ready[0])
  );

  ysyx_24110006_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(16), .BYPASS_EN(1'b0)) u_d1 (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_wen(i_wen),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .o_rdata1(rdata1[1]), .o_rdata2(rdata2[1]), .i_issue_valid(i_issue_valid),
    .i_issue_rd(i_issue_rd), .o_busy1(busy1[1]), .o_busy2(busy2[1]), .o_ready(ready[1])
  );

  ysyx_24110006_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(32), .BYPASS_EN(1'b1)) u_d2 (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_wen(i_wen),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .o_rdata1(rdata1[2]), .o_rdata2(rdata2[2]), .i_issue_valid(i_issue_valid),
    .i_issue_rd(i_issue_rd), .o_busy1(busy1[2]), .o_busy2(busy2[2]), .o_ready(ready[2])
  );

  function automatic logic [31:0] getOutput(input int dut, input int sig);
    logic [1:0] d;
    d = 2'(dut);
    case (sig)
      S_RD1:   return rdata1[d];
      S_RD2:   return rdata2[d];
      S_BUSY1: return {31'b0, busy1[d]};
      S_BUSY2: return {31'b0, busy2[d]};
      default: return {31'b0, ready[d]};
    endcase
  endfunction

  // Queues an expectation for the cycle currently being driven.
  task automatic checkOutput(input int dut, input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic rstn, input logic v, input logic we,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                               input logic iv, input logic [AW-1:0] ird);
    @(posedge i_clock);
    #1;
    i_reset_n     = rstn;
    i_valid       = v;
    i_wen         = we;
    i_waddr       = wa;
    i_wdata       = wd;
    i_raddr1      = ra1;
    i_raddr2      = ra2;
    i_issue_valid = iv;
    i_issue_rd    = ird;
  endtask

  task automatic idle(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, ra1, ra2, 1'b0, '0);
  endtask

  // One reset cycle then the full sweep, with a write and an issue thrown at
  // the block while it is still clearing.
  task automatic runSweep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 5'd9, 5'd4, 1'b0, '0);
    for (int d = 0; d < 3; d++) begin
      checkOutput(d, S_READY, 0, "ready_in_reset");
      checkOutput(d, S_BUSY1, 0, "busy1_in_reset");
    end
    for (int i = 1; i <= 32; i++) begin
      if (i == 10)
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 32'hAB, 5'd4, 5'd3, 1'b0, '0);
      else if (i == 5)
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 5'd4, 5'd3, 1'b1, 5'd4);
      else
        idle(5'd4, 5'd3);
      checkOutput(0, S_READY, 32'(i >= 16), "ready_sweep_d0");
      checkOutput(1, S_READY, 32'(i >= 16), "ready_sweep_d1");
      checkOutput(2, S_READY, 32'(i >= 32), "ready_sweep_d2");
      if (i < 16) begin
        checkOutput(0, S_RD1, 0, "rdata_in_clear");
        checkOutput(0, S_BUSY1, 0, "busy_in_clear");
      end
    end
  endtask

  always @(negedge i_clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = getOutput(mon_e.dut, mon_e.sig);
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h",
                 mon_e.name, mon_e.dut, mon_e.cyc, mon_act, mon_e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    runSweep();

    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 5'(i), 32'hFFFF_FFFF, 5'(i), '0, 1'b0, '0);
      checkOutput(0, S_RD1, 32'hFFFF_FFFF, "preload_bypass_d0");
      checkOutput(1, S_RD1, 32'h0, "preload_nobypass_d1");
    end
    idle(5'd15, 5'd1);
    checkOutput(1, S_RD1, 32'hFFFF_FFFF, "preload_r15");
    checkOutput(1, S_RD2, 32'hFFFF_FFFF, "preload_r1");

    runSweep();
    for (int i = 1; i <= 15; i++) begin
      idle(5'(i), 5'(16 - i));
      checkOutput(0, S_RD1, 0, "swept_rd1");
      checkOutput(0, S_RD2, 0, "swept_rd2");
      checkOutput(0, S_BUSY1, 0, "swept_busy1");
      checkOutput(0, S_BUSY2, 0, "swept_busy2");
      checkOutput(2, S_RD1, 0, "swept_rd1_d2");
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    for (int i = 1; i <= 5; i++) begin
      idle('0, '0);
      checkOutput(0, S_READY, 0, "ready_partial_sweep");
    end
    runSweep();
    idle(5'd3, 5'd4);
    checkOutput(0, S_RD1, 0, "clear_write_dropped");
    checkOutput(0, S_BUSY2, 0, "clear_issue_dropped");
    checkOutput(2, S_RD1, 0, "clear_write_dropped_d2");

    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 32'h1234_5678, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, '0, '0, 1'b0, '0);
    checkOutput(0, S_RD1, 0, "x0_no_bypass");
    idle(5'd5, 5'd0);
    checkOutput(0, S_RD1, 32'h1234_5678, "read_r5");
    checkOutput(0, S_RD2, 0, "read_x0");
    checkOutput(1, S_RD1, 32'h1234_5678, "read_r5_d1");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd5, 1'b0, '0);
    checkOutput(0, S_RD1, 32'h1234_5678, "invalid_write_no_bypass");
    idle(5'd5, 5'd5);
    checkOutput(0, S_RD2, 32'h1234_5678, "invalid_write_dropped");

    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd7, 1'b0, '0);
    checkOutput(0, S_RD1, 32'hCAFE_F00D, "bypass_rd1");
    checkOutput(0, S_RD2, 32'hCAFE_F00D, "bypass_rd2");
    checkOutput(1, S_RD1, 0, "nobypass_rd1_old");
    checkOutput(1, S_RD2, 0, "nobypass_rd2_old");
    checkOutput(2, S_RD1, 32'hCAFE_F00D, "bypass_rd1_d2");
    idle(5'd7, 5'd7);
    checkOutput(1, S_RD1, 32'hCAFE_F00D, "nobypass_rd1_next");
    checkOutput(1, S_RD2, 32'hCAFE_F00D, "nobypass_rd2_next");

    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 5'd9, 5'd9, 1'b1, 5'd9);
    checkOutput(0, S_BUSY1, 0, "busy_before_issue_edge");
    idle(5'd9, 5'd9);
    for (int d = 0; d < 3; d++) begin
      checkOutput(d, S_BUSY1, 1, "busy1_after_issue");
      checkOutput(d, S_BUSY2, 1, "busy2_after_issue");
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd9, 1'b0, '0);
    checkOutput(0, S_BUSY1, 0, "busy_bypass_clear");
    checkOutput(1, S_BUSY1, 1, "busy_nobypass_held");
    checkOutput(0, S_RD1, 32'h99, "wb_bypass_data");
    checkOutput(1, S_RD1, 0, "wb_nobypass_data");
    checkOutput(2, S_BUSY2, 0, "busy_bypass_clear_d2");
    idle(5'd9, 5'd9);
    checkOutput(0, S_BUSY1, 0, "pending_cleared_d0");
    checkOutput(1, S_BUSY1, 0, "pending_cleared_d1");
    checkOutput(1, S_RD1, 32'h99, "wb_committed_d1");
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 32'hA5, 5'd9, 5'd9, 1'b1, 5'd9);
    checkOutput(0, S_BUSY1, 0, "issue_and_wb_bypass");
    checkOutput(1, S_BUSY1, 0, "issue_and_wb_nobypass");
    idle(5'd9, 5'd9);
    for (int d = 0; d < 3; d++) begin
      checkOutput(d, S_BUSY1, 1, "issue_wins_over_wb");
    end
    checkOutput(1, S_RD1, 32'hA5, "issue_and_wb_data");
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 32'hB6, 5'd9, 5'd10, 1'b1, 5'd10);
    checkOutput(0, S_BUSY1, 0, "indep_bypass_r9");
    checkOutput(1, S_BUSY1, 1, "indep_nobypass_r9");
    checkOutput(0, S_BUSY2, 0, "indep_r10_not_yet");
    idle(5'd9, 5'd10);
    for (int d = 0; d < 3; d++) begin
      checkOutput(d, S_BUSY1, 0, "indep_r9_cleared");
      checkOutput(d, S_BUSY2, 1, "indep_r10_pending");
    end
    checkOutput(0, S_RD1, 32'hB6, "indep_r9_data");

    applyStimulus(1'b1, 1'b1, 1'b1, 5'd17, 32'h55, 5'd17, 5'd20, 1'b1, 5'd20);
    checkOutput(0, S_RD1, 0, "oor_no_bypass");
    checkOutput(2, S_RD1, 32'h55, "r17_bypass_d2");
    checkOutput(0, S_BUSY2, 0, "oor_busy_same_cycle");
    idle(5'd17, 5'd1);
    checkOutput(0, S_RD1, 0, "oor_read_17");
    checkOutput(0, S_RD2, 0, "no_alias_r1");
    checkOutput(1, S_RD2, 0, "no_alias_r1_d1");
    checkOutput(2, S_RD1, 32'h55, "r17_stored_d2");
    checkOutput(2, S_RD2, 0, "r1_untouched_d2");
    idle(5'd20, 5'd17);
    checkOutput(0, S_BUSY1, 0, "oor_issue_ignored");
    checkOutput(0, S_BUSY2, 0, "oor_busy_17");
    checkOutput(2, S_BUSY1, 1, "r20_pending_d2");
    checkOutput(2, S_RD2, 32'h55, "r17_port2_d2");

    idle('0, '0);
    idle('0, '0);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_regfile_sb.md
Name: ysyx_24110006_regfile_sb

Overview:
Parametrised general-purpose register file for the ysyx core. Supports RV32E (16 entries) or RV32I (32 entries) depth and a configurable data width. Adds a reset-time clearing sweep, optional write-to-read bypass, and a per-register pending scoreboard so decode can detect RAW hazards against in-flight writebacks. Sits between decode (read and issue side) and writeback (write side).

Parameters:
ADDR_WIDTH, 5, width of all register address ports
DATA_WIDTH, 32, register data width
NUM_REGS, 16, number of architectural entries; legal values are 16 or 32, and NUM_REGS <= 2**ADDR_WIDTH
BYPASS_EN, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only

Ports:
i_clock  in  1  clock; all state updates on the rising edge
i_reset_n  in  1  reset, synchronous, active-low
i_valid  in  1  writeback slot valid
i_wen  in  1  write enable; a write occurs only when i_valid is also 1
i_waddr  in  ADDR_WIDTH  write address
i_wdata  in  DATA_WIDTH  write data
i_raddr1  in  ADDR_WIDTH  read port 1 address
i_raddr2  in  ADDR_WIDTH  read port 2 address
o_rdata1  out  DATA_WIDTH  read port 1 data, combinational
o_rdata2  out  DATA_WIDTH  read port 2 data, combinational
i_issue_valid  in  1  an instruction with destination i_issue_rd has issued
i_issue_rd  in  ADDR_WIDTH  destination of the issued instruction
o_busy1  out  1  read port 1 register has a pending write
o_busy2  out  1  read port 2 register has a pending write
o_ready  out  1  block accepts writes and issues

Behaviour:
- Clock and reset: one clock (i_clock); reset i_reset_n is synchronous and active-low.
- Reset state:
  - While i_reset_n = 0 at an edge: state <- CLEAR, clear pointer <- 1, all pending bits <- 0.
  - Output values during reset: o_ready = 0, o_busy1 = 0, o_busy2 = 0.
- State machine, two states:
  - CLEAR: each cycle write 0 to entry[ptr], then ptr <- ptr + 1. When ptr == NUM_REGS-1 is written, next state is READY. The sweep takes NUM_REGS-1 cycles after reset is released.
  - READY: normal operation. Stays in READY until i_reset_n = 0.
  - Reset asserted mid-sweep restarts the sweep at ptr = 1.
- o_ready = 1 only in READY.
  - In CLEAR, writeback writes and issues are ignored; they are not queued.
  - In CLEAR, both read ports return 0.
- Entry 0 is hardwired to zero: no storage, reads 0, writes dropped, never pending.
- Address range: an address >= NUM_REGS is out of range. It reads 0, its writes are dropped, and issues to it are ignored. There is no truncation aliasing. Example: with NUM_REGS=16, address 17 is not entry 1.
- Write commit: a write takes effect at the rising edge when all of the following hold:
  - o_ready = 1, i_valid = 1, i_wen = 1
  - i_waddr != 0 and i_waddr is in range
- Read latency: 0 (combinational) from stored state.
- Bypass:
  - BYPASS_EN=1: if a committing write's i_waddr equals i_raddrK, o_rdataK = i_wdata in that same cycle.
  - BYPASS_EN=0: o_rdataK returns the old value until the edge.
- Scoreboard:
  - pending[r] is set at the edge when o_ready = 1, i_issue_valid = 1, i_issue_rd = r, and r is legal and nonzero.
  - pending[r] is cleared at the edge when a write to r commits.
  - If an issue and a write target the same r at the same edge, the set wins (a new producer).
  - Issues and writes to different registers at the same edge are independent.
- Busy flags:
  - o_busyK = pending[i_raddrK].
  - Exception: when BYPASS_EN=1 and a committing write to i_raddrK is present this cycle, o_busyK = 0.
  - o_busyK is always 0 for entry 0, for out-of-range addresses, and in CLEAR.
- Both read ports may address the same register; both return identical data and busy values.

Test Plan:
- Reset and sweep: pre-load entries 1..15 with 0xFFFFFFFF, pulse i_reset_n=0 for 1 cycle -> o_ready=0 for exactly 15 cycles; afterwards every read returns 0 and o_busy1=o_busy2=0.
- Reset mid-sweep: deassert reset, re-assert it after 5 cycles, then release -> o_ready rises exactly 15 cycles after the final release; a write attempted during CLEAR is not retained.
- Write/read and x0: write 0x12345678 to r5 and 0xDEADBEEF to r0 -> next cycle raddr1=5 gives 0x12345678 and raddr2=0 gives 0; an i_wen=1, i_valid=0 write to r5 leaves r5 unchanged.
- Bypass: BYPASS_EN=1, write 0xCAFEF00D to r7 with raddr1=raddr2=7 in the same cycle -> both read ports show 0xCAFEF00D that cycle. With BYPASS_EN=0 the same stimulus shows the old value, and 0xCAFEF00D appears the cycle after.
- Scoreboard: issue rd=9 -> the next cycle with raddr1=9 gives o_busy1=1. Write r9 with raddr1=9 in the same cycle -> o_busy1=0 (BYPASS_EN=1), pending cleared after the edge. Issue rd=9 and write r9 at the same edge -> r9 is still pending afterwards.
- Range and depth: NUM_REGS=16, write 0x55 to address 17 and issue rd=20 -> reads of 17 and of 1 are unaffected (0); o_busy for 20 is 0. With NUM_REGS=32, address 17 stores and reads 0x55.
